// File: rtl/pll_dyn_cfg_ctrl.sv
// pll_dyn_cfg_ctrl: drives PLL dynamic-reconfiguration fields, PLL reset and lock qualification.
// Build option: define PLL_LOCK_AUTO_RECOVER_EN to pulse the PLL reset after a lock loss.
module pll_dyn_cfg_ctrl #(
    parameter int unsigned RST_CYC      = 4,
    parameter int unsigned LOCK_TIMEOUT = 20000,
    parameter int unsigned LOCK_FILT    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [2:0]  cfg_sel,
    input  logic [9:0]  cfg_odiv,
    input  logic [9:0]  cfg_duty,
    input  logic [12:0] cfg_phase,
    input  logic        pll_lock,
    output logic        pll_rst,
    output logic [49:0] dyn_odiv,
    output logic [49:0] dyn_duty,
    output logic [64:0] dyn_phase,
    output logic        lock_ok,
    output logic        cfg_done,
    output logic        cfg_err,
    output logic [7:0]  lock_loss_cnt
);
    typedef enum logic [1:0] {IDLE, APPLY, RST, WAIT_LOCK} state_t;

    localparam logic [7:0]  FILT_MAX  = 8'(LOCK_FILT);
    localparam logic [7:0]  RST_LAST  = 8'(RST_CYC - 1);
    localparam logic [19:0] TO_LAST   = 20'(LOCK_TIMEOUT - 1);
    localparam logic [9:0]  ODIV_RST  = 10'd100;
    localparam logic [9:0]  DUTY_RST  = 10'd100;
    localparam logic [12:0] PHASE_RST = 13'd16;

    state_t           state_q, state_d;
    logic             lock_meta_q, lock_s_q;
    logic [7:0]       filt_q, filt_d;
    logic [19:0]      to_q, to_d;
    logic [7:0]       rc_q, rc_d;
    logic [2:0]       req_sel_q, req_sel_d;
    logic [9:0]       req_odiv_q, req_odiv_d;
    logic [9:0]       req_duty_q, req_duty_d;
    logic [12:0]      req_phase_q, req_phase_d;
    logic [4:0][9:0]  odiv_q, odiv_d;
    logic [4:0][9:0]  duty_q, duty_d;
    logic [4:0][12:0] phase_q, phase_d;
    logic [7:0]       loss_q, loss_d;
    logic             pll_rst_q, pll_rst_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    // Two-stage synchronizer for the asynchronous lock input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= pll_lock;
            lock_s_q    <= lock_meta_q;
        end
    end

    // State, counters, captured request and output field registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT_LOCK;
            filt_q      <= '0;
            to_q        <= '0;
            rc_q        <= '0;
            req_sel_q   <= '0;
            req_odiv_q  <= '0;
            req_duty_q  <= '0;
            req_phase_q <= '0;
            odiv_q      <= {5{ODIV_RST}};
            duty_q      <= {5{DUTY_RST}};
            phase_q     <= {5{PHASE_RST}};
            loss_q      <= '0;
            pll_rst_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            filt_q      <= filt_d;
            to_q        <= to_d;
            rc_q        <= rc_d;
            req_sel_q   <= req_sel_d;
            req_odiv_q  <= req_odiv_d;
            req_duty_q  <= req_duty_d;
            req_phase_q <= req_phase_d;
            odiv_q      <= odiv_d;
            duty_q      <= duty_d;
            phase_q     <= phase_d;
            loss_q      <= loss_d;
            pll_rst_q   <= pll_rst_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Next-state, counter and field update logic
    always_comb begin
        state_d     = state_q;
        filt_d      = '0;
        to_d        = '0;
        rc_d        = '0;
        req_sel_d   = req_sel_q;
        req_odiv_d  = req_odiv_q;
        req_duty_d  = req_duty_q;
        req_phase_d = req_phase_q;
        odiv_d      = odiv_q;
        duty_d      = duty_q;
        phase_d     = phase_q;
        loss_d      = loss_q;
        pll_rst_d   = (state_q == RST);
        done_d      = 1'b0;
        err_d       = 1'b0;
        if (lock_s_q) begin
            filt_d = (filt_q == FILT_MAX) ? filt_q : filt_q + 8'd1;
        end
        unique case (state_q)
            IDLE: begin
                if (!lock_s_q) begin
                    if (loss_q != 8'hFF) begin
                        loss_d = loss_q + 8'd1;
                    end
`ifdef PLL_LOCK_AUTO_RECOVER_EN
                    state_d = RST;
`else
                    state_d = WAIT_LOCK;
`endif
                end else if (cfg_valid) begin
                    if (cfg_sel == 3'd5 || cfg_sel == 3'd6) begin
                        err_d = 1'b1;
                    end else begin
                        req_sel_d   = cfg_sel;
                        req_odiv_d  = cfg_odiv;
                        req_duty_d  = cfg_duty;
                        req_phase_d = cfg_phase;
                        state_d     = APPLY;
                    end
                end
            end
            APPLY: begin
                for (int i = 0; i < 5; i++) begin
                    if (req_sel_q == 3'd7 || int'(req_sel_q) == i) begin
                        odiv_d[i]  = req_odiv_q;
                        duty_d[i]  = req_duty_q;
                        phase_d[i] = req_phase_q;
                    end
                end
                state_d = RST;
            end
            RST: begin
                filt_d = '0;
                if (rc_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                end else begin
                    rc_d = rc_q + 8'd1;
                end
            end
            WAIT_LOCK: begin
                to_d = to_q + 20'd1;
                if (filt_q == FILT_MAX) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (to_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = RST;
                end
            end
        endcase
    end

    assign cfg_ready     = (state_q == IDLE);
    assign lock_ok       = (state_q == IDLE);
    assign pll_rst       = pll_rst_q;
    assign dyn_odiv      = odiv_q;
    assign dyn_duty      = duty_q;
    assign dyn_phase     = phase_q;
    assign cfg_done      = done_q;
    assign cfg_err       = err_q;
    assign lock_loss_cnt = loss_q;
endmodule
